// File: rtl/mux_n_registrado.sv
// mux_n_registrado: N-input, W-bit registered multiplexer with valid/ready
// handshakes on both sides and a two-entry skid buffer. Out-of-range selects
// yield VALOR_PADRAO and raise a sticky error flag. Emits are counted.
module mux_n_registrado #(
  parameter int                   LARGURA      = 32,
  parameter int                   ENTRADAS     = 3,
  parameter int                   SEL_W        = $clog2(ENTRADAS),
  parameter logic [LARGURA-1:0]   VALOR_PADRAO = '0
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [ENTRADAS*LARGURA-1:0]   entradas,
  input  logic [SEL_W-1:0]              seletor,
  input  logic                          valido_in,
  output logic                          pronto_in,
  output logic [LARGURA-1:0]            saida,
  output logic                          valido_out,
  input  logic                          pronto_out,
  output logic                          erro_sel,
  input  logic                          limpa_erro,
  output logic [15:0]                   contador_transf
);

  typedef enum logic [1:0] {
    VAZIO = 2'd0,
    CHEIO = 2'd1,
    SKID  = 2'd2
  } estado_t;

  estado_t              r_estado;
  estado_t              w_proxEstado;
  logic [LARGURA-1:0]   r_principal;
  logic [LARGURA-1:0]   r_skid;
  logic                 r_erroSel;
  logic [15:0]          r_contador;

  logic [LARGURA-1:0]   w_selVal;
  logic                 w_foraFaixa;
  logic                 w_prontoIn;
  logic                 w_validoOut;
  logic                 w_aceita;
  logic                 w_emite;

  assign w_aceita = valido_in & w_prontoIn;
  assign w_emite  = w_validoOut & pronto_out;

  // Pick the addressed input word, falling back to the default for indices past the last input
  always_comb begin
    w_selVal    = VALOR_PADRAO;
    w_foraFaixa = (int'(seletor) >= ENTRADAS);
    for (int i = 0; i < ENTRADAS; i++) begin
      if (int'(seletor) == i) begin
        w_selVal = entradas[i*LARGURA +: LARGURA];
      end
    end
  end

  // State register for the skid-buffer control
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado <= VAZIO;
    end else begin
      r_estado <= w_proxEstado;
    end
  end

  // Next state: occupancy grows on accept without emit and shrinks on emit without accept
  always_comb begin
    w_proxEstado = r_estado;
    case (r_estado)
      VAZIO: begin
        if (w_aceita) w_proxEstado = CHEIO;
      end
      CHEIO: begin
        if (w_aceita && !w_emite)      w_proxEstado = SKID;
        else if (!w_aceita && w_emite) w_proxEstado = VAZIO;
      end
      SKID: begin
        if (w_emite) w_proxEstado = CHEIO;
      end
      default: w_proxEstado = VAZIO;
    endcase
  end

  // Handshake outputs decode the state register only, so no ready/valid input reaches an output
  always_comb begin
    w_validoOut = (r_estado != VAZIO);
    w_prontoIn  = (r_estado != SKID);
  end

  // Data registers: principal always holds the oldest word, skid the one that arrived under stall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_principal <= '0;
      r_skid      <= '0;
    end else begin
      case (r_estado)
        VAZIO: begin
          if (w_aceita) r_principal <= w_selVal;
        end
        CHEIO: begin
          if (w_aceita && w_emite)       r_principal <= w_selVal;
          else if (w_aceita && !w_emite) r_skid      <= w_selVal;
        end
        SKID: begin
          if (w_emite) r_principal <= r_skid;
        end
        default: begin
          r_principal <= r_principal;
        end
      endcase
    end
  end

  // Sticky select error: a bad accept sets it and takes priority over a clear in the same cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_erroSel <= 1'b0;
    end else if (w_aceita && w_foraFaixa) begin
      r_erroSel <= 1'b1;
    end else if (limpa_erro) begin
      r_erroSel <= 1'b0;
    end
  end

  // Count output transfers, wrapping naturally at 16 bits
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_contador <= '0;
    end else if (w_emite) begin
      r_contador <= r_contador + 16'd1;
    end
  end

  assign pronto_in       = w_prontoIn;
  assign valido_out      = w_validoOut;
  assign saida           = r_principal;
  assign erro_sel        = r_erroSel;
  assign contador_transf = r_contador;

endmodule

// File: tb/tb_mux_n_registrado.sv
// tb_mux_n_registrado: directed, table-driven bench for mux_n_registrado
// with ENTRADAS=3, LARGURA=32 and VALOR_PADRAO=0xDEAD.
module tb_mux_n_registrado;

  localparam int LARGURA  = 32;
  localparam int ENTRADAS = 3;
  localparam int SEL_W    = 2;

  logic                        clock;
  logic                        reset_n;
  logic [ENTRADAS*LARGURA-1:0] entradas;
  logic [SEL_W-1:0]            seletor;
  logic                        valido_in;
  logic                        pronto_in;
  logic [LARGURA-1:0]          saida;
  logic                        valido_out;
  logic                        pronto_out;
  logic                        erro_sel;
  logic                        limpa_erro;
  logic [15:0]                 contador_transf;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [31:0] wordA;
    logic [31:0] wordB;
    logic [31:0] wordC;
    logic [1:0]  sel;
    logic [31:0] expSaida;
  } vector_t;

  vector_t vetores [8];

  mux_n_registrado #(
    .LARGURA      (LARGURA),
    .ENTRADAS     (ENTRADAS),
    .SEL_W        (SEL_W),
    .VALOR_PADRAO (32'h0000_DEAD)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .entradas        (entradas),
    .seletor         (seletor),
    .valido_in       (valido_in),
    .pronto_in       (pronto_in),
    .saida           (saida),
    .valido_out      (valido_out),
    .pronto_out      (pronto_out),
    .erro_sel        (erro_sel),
    .limpa_erro      (limpa_erro),
    .contador_transf (contador_transf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive the upstream side; input 0 sits in the low bits of entradas
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [1:0] sel,
                               input logic valid);
    entradas  = {c, b, a};
    seletor   = sel;
    valido_in = valid;
  endtask

  // Advance one rising edge and settle 1 time unit after it
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string nome, input logic [31:0] atual,
                             input logic [31:0] esperado);
    testsRun++;
    if (atual !== esperado) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nome, atual, esperado);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    vetores[0] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 2'd0, 32'h0000_1000};
    vetores[1] = '{32'h0000_1001, 32'h0000_2001, 32'h0000_3001, 2'd1, 32'h0000_2001};
    vetores[2] = '{32'h0000_1002, 32'h0000_2002, 32'h0000_3002, 2'd2, 32'h0000_3002};
    vetores[3] = '{32'hAAAA_0003, 32'hBBBB_0003, 32'hCCCC_0003, 2'd0, 32'hAAAA_0003};
    vetores[4] = '{32'hAAAA_0004, 32'hBBBB_0004, 32'hCCCC_0004, 2'd1, 32'hBBBB_0004};
    vetores[5] = '{32'hAAAA_0005, 32'hBBBB_0005, 32'hCCCC_0005, 2'd2, 32'hCCCC_0005};
    vetores[6] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h1234_5678, 2'd0, 32'hFFFF_FFFF};
    vetores[7] = '{32'h8765_4321, 32'h0000_0001, 32'h5555_AAAA, 2'd1, 32'h0000_0001};

    // Reset state
    reset_n    = 1'b0;
    pronto_out = 1'b1;
    limpa_erro = 1'b0;
    applyStimulus(32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    #1;
    checkOutput("reset saida",      saida, 32'h0);
    checkOutput("reset valido_out", 32'(valido_out), 32'h0);
    checkOutput("reset pronto_in",  32'(pronto_in), 32'h1);
    checkOutput("reset erro_sel",   32'(erro_sel), 32'h0);
    checkOutput("reset contador",   32'(contador_transf), 32'h0);
    step();
    reset_n = 1'b1;
    step();

    // Single word, select 2, one-cycle latency then drained
    applyStimulus(32'hA, 32'hB, 32'hC, 2'd2, 1'b1);
    step();
    checkOutput("single saida",      saida, 32'hC);
    checkOutput("single valido_out", 32'(valido_out), 32'h1);
    applyStimulus(32'hA, 32'hB, 32'hC, 2'd2, 1'b0);
    step();
    checkOutput("single drained valido_out", 32'(valido_out), 32'h0);
    checkOutput("single contador",           32'(contador_transf), 32'd1);

    // Streaming: back-to-back words at one per cycle
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vetores[i].wordA, vetores[i].wordB, vetores[i].wordC,
                    vetores[i].sel, 1'b1);
      step();
      checkOutput($sformatf("stream[%0d] saida", i), saida, vetores[i].expSaida);
      checkOutput($sformatf("stream[%0d] valido_out", i), 32'(valido_out), 32'h1);
      checkOutput($sformatf("stream[%0d] pronto_in", i), 32'(pronto_in), 32'h1);
    end
    applyStimulus(32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    step();
    checkOutput("stream valido_out idle", 32'(valido_out), 32'h0);
    checkOutput("stream contador",        32'(contador_transf), 32'd9);
    checkOutput("stream erro_sel",        32'(erro_sel), 32'h0);

    // Backpressure: three words offered while downstream stalls
    pronto_out = 1'b0;
    applyStimulus(32'h111, 32'h0, 32'h0, 2'd0, 1'b1);
    step();
    checkOutput("bp w1 saida",     saida, 32'h111);
    checkOutput("bp w1 pronto_in", 32'(pronto_in), 32'h1);
    applyStimulus(32'h0, 32'h222, 32'h0, 2'd1, 1'b1);
    step();
    checkOutput("bp w2 pronto_in", 32'(pronto_in), 32'h0);
    checkOutput("bp w2 saida",     saida, 32'h111);
    applyStimulus(32'h0, 32'h0, 32'h333, 2'd2, 1'b1);
    step();
    checkOutput("bp stall pronto_in",  32'(pronto_in), 32'h0);
    checkOutput("bp stall saida",      saida, 32'h111);
    checkOutput("bp stall valido_out", 32'(valido_out), 32'h1);
    step();
    checkOutput("bp stall2 saida",    saida, 32'h111);
    checkOutput("bp stall2 contador", 32'(contador_transf), 32'd9);
    pronto_out = 1'b1;
    step();
    checkOutput("bp release saida",     saida, 32'h222);
    checkOutput("bp release pronto_in", 32'(pronto_in), 32'h1);
    checkOutput("bp release contador",  32'(contador_transf), 32'd10);
    step();
    checkOutput("bp w3 saida",    saida, 32'h333);
    checkOutput("bp w3 contador", 32'(contador_transf), 32'd11);
    applyStimulus(32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    step();
    checkOutput("bp drained valido_out", 32'(valido_out), 32'h0);
    checkOutput("bp drained contador",   32'(contador_transf), 32'd12);

    // Out-of-range select yields the default word and a sticky error
    applyStimulus(32'h1, 32'h2, 32'h3, 2'd3, 1'b1);
    step();
    checkOutput("oor saida",    saida, 32'h0000_DEAD);
    checkOutput("oor erro_sel", 32'(erro_sel), 32'h1);
    applyStimulus(32'h1, 32'h2, 32'h3, 2'd0, 1'b0);
    step();
    step();
    checkOutput("oor sticky erro_sel", 32'(erro_sel), 32'h1);
    limpa_erro = 1'b1;
    step();
    limpa_erro = 1'b0;
    checkOutput("oor cleared erro_sel", 32'(erro_sel), 32'h0);
    applyStimulus(32'h1, 32'h2, 32'h3, 2'd3, 1'b1);
    limpa_erro = 1'b1;
    step();
    limpa_erro = 1'b0;
    checkOutput("oor set-wins erro_sel", 32'(erro_sel), 32'h1);
    checkOutput("oor set-wins saida",    saida, 32'h0000_DEAD);
    applyStimulus(32'h1, 32'h2, 32'h3, 2'd0, 1'b0);
    step();
    checkOutput("oor contador", 32'(contador_transf), 32'd14);

    // Async reset while holding two words in SKID
    pronto_out = 1'b0;
    applyStimulus(32'h444, 32'h0, 32'h0, 2'd0, 1'b1);
    step();
    applyStimulus(32'h555, 32'h0, 32'h0, 2'd0, 1'b1);
    step();
    checkOutput("skid pronto_in before reset", 32'(pronto_in), 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset valido_out", 32'(valido_out), 32'h0);
    checkOutput("async reset pronto_in",  32'(pronto_in), 32'h1);
    checkOutput("async reset saida",      saida, 32'h0);
    checkOutput("async reset erro_sel",   32'(erro_sel), 32'h0);
    checkOutput("async reset contador",   32'(contador_transf), 32'h0);
    applyStimulus(32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    step();
    reset_n    = 1'b1;
    pronto_out = 1'b1;
    applyStimulus(32'h0, 32'h666, 32'h0, 2'd1, 1'b1);
    step();
    checkOutput("post-reset saida",      saida, 32'h666);
    checkOutput("post-reset valido_out", 32'(valido_out), 32'h1);
    applyStimulus(32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    step();
    checkOutput("post-reset contador", 32'(contador_transf), 32'd1);

    // Counter wrap after 65536 emits, starting from a fresh reset
    #2;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    applyStimulus(32'h7, 32'h8, 32'h9, 2'd0, 1'b1);
    for (int i = 0; i < 65536; i++) begin
      step();
    end
    checkOutput("wrap contador pre", 32'(contador_transf), 32'hFFFF);
    applyStimulus(32'h7, 32'h8, 32'h9, 2'd0, 1'b0);
    step();
    checkOutput("wrap contador",      32'(contador_transf), 32'h0);
    checkOutput("wrap valido_out",    32'(valido_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mux_n_registrado.md
# mux_n_registrado

Parametrised N-input, W-bit registered multiplexer with a valid/ready handshake on both sides and a two-entry skid buffer. It selects one of `ENTRADAS` packed input words and delivers the result one cycle later, at a sustained rate of one word per cycle. It replaces fixed-width combinational selectors on datapath paths that cross a pipeline stage boundary, such as forwarding and write-back selection. It adds defined behaviour for out-of-range selects, a sticky error flag and a transfer counter.

## Interface
- `LARGURA`, 32: data width in bits (≥1).
- `ENTRADAS`, 3: number of inputs (2..16).
- `SEL_W`, `$clog2(ENTRADAS)`: selector width.
- `VALOR_PADRAO`, 0: word emitted for an out-of-range select.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `entradas`  in  ENTRADAS*LARGURA  packed inputs; input i occupies bits [i*LARGURA +: LARGURA].
- `seletor`  in  SEL_W  input index, sampled on accept.
- `valido_in`  in  1  upstream word valid.
- `pronto_in`  out  1  block can accept a word.
- `saida`  out  LARGURA  selected word, registered.
- `valido_out`  out  1  `saida` valid.
- `pronto_out`  in  1  downstream accepts `saida`.
- `erro_sel`  out  1  sticky: an out-of-range select was accepted.
- `limpa_erro`  in  1  clears `erro_sel`.
- `contador_transf`  out  16  count of output transfers, wraps.

## Operation
- Accept = `valido_in & pronto_in`. Emit = `valido_out & pronto_out`.
- Selected word `sel_val` = `entradas[seletor]` if `seletor < ENTRADAS`, else `VALOR_PADRAO`.
- There are two storage registers: `principal`, which drives `saida`, and `skid`.
- FSM states: VAZIO, CHEIO, SKID. `valido_out` = (state != VAZIO). `pronto_in` = (state != SKID).
- VAZIO:
  - On accept, `principal` ← `sel_val` and the FSM goes to CHEIO.
- CHEIO:
  - Accept and emit: `principal` ← `sel_val`, stay in CHEIO.
  - Accept, no emit: `skid` ← `sel_val`, go to SKID.
  - Emit only: go to VAZIO; `principal` holds its old value.
  - Neither: hold.
- SKID: no accept is possible.
  - Emit: `principal` ← `skid`, go to CHEIO.
  - Otherwise hold.
- `saida` must not change while `valido_out=1` and `pronto_out=0`.
- `erro_sel` is set on any accept with `seletor ≥ ENTRADAS`. It is cleared by `limpa_erro`. Set wins over clear in the same cycle.
- `contador_transf` increments by 1 on each emit and wraps from 0xFFFF to 0x0000.
- When `ENTRADAS` is a power of two, no select is out of range and `erro_sel` stays 0.

## Timing
- Reset (async assert, sync release), all outputs:
  - state VAZIO;
  - `saida`=0, `skid`=0;
  - `valido_out`=0;
  - `pronto_in`=1;
  - `erro_sel`=0;
  - `contador_transf`=0.
- Reset asserted mid-operation discards both stored words immediately, with no emit.
- Latency is 1 cycle: a word accepted at edge k is visible on `saida` with `valido_out=1` after edge k.
- Throughput is 1 word per cycle while `pronto_out=1`.
- `pronto_in` and `valido_out` are decoded from state registers only. There is no combinational path from `pronto_out` or `valido_in` to any output.
- `pronto_in` falls the cycle after the second unconsumed word is accepted. It rises the cycle after the emit that drains `skid`.
- Ordering is strict FIFO over at most 2 words. No word is dropped or duplicated.
- Upstream must hold `entradas`, `seletor` and `valido_in` stable while `valido_in=1` and `pronto_in=0`. The block only samples them on accept.

## Test plan
- Reset, then `ENTRADAS=3`, `LARGURA=32`:
  - drive input words 0xA, 0xB, 0xC, `seletor`=2, `valido_in`=1 for one cycle, `pronto_out`=1;
  - required: `saida`=0xC with `valido_out`=1 one cycle later, then `valido_out`=0 and `contador_transf`=1.
- Streaming: 8 back-to-back words with `seletor` cycling 0,1,2, `pronto_out`=1;
  - required: outputs in the same order at 1 word/cycle, `pronto_in` constantly 1, `contador_transf`=8.
- Backpressure: `pronto_out`=0 while 3 words are offered;
  - required: the first 2 are accepted and `pronto_in`=0 from the cycle after the second;
  - `saida` holds word 1;
  - releasing `pronto_out` yields word 1, then word 2, then word 3 accepted, none lost.
- Out-of-range: `seletor`=3 with `ENTRADAS=3`, `VALOR_PADRAO`=0xDEAD;
  - required: `saida`=0xDEAD, `erro_sel`=1 and staying 1;
  - `limpa_erro` pulse clears it;
  - `limpa_erro` in the same cycle as a new bad select leaves it at 1.
- Counter wrap: force 65 536 emits;
  - required: `contador_transf` returns to 0x0000.
- Async reset while in state SKID:
  - required: `valido_out`=0, `pronto_in`=1, `saida`=0 immediately with no clock edge;
  - after release, the first new word appears after 1 cycle.
